// File: rtl/store_buffer.sv
// store_buffer: FIFO of word-aligned, lane-aligned stores that drain to data memory,
// searched by MEM-stage loads. Define STORE_BUF_FWD_EN to enable store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          st_valid,
  output logic                          st_ready,
  input  logic [DM_ADDRESS-1:0]         st_addr,
  input  logic [DATA_W-1:0]             st_data,
  input  logic [2:0]                    st_funct3,
  input  logic                          ld_valid,
  input  logic [DM_ADDRESS-1:0]         ld_addr,
  input  logic [2:0]                    ld_funct3,
  output logic                          mem_we,
  output logic [DM_ADDRESS-1:0]         mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [3:0]                    mem_wr,
  output logic                          fwd_hit,
  output logic [DATA_W-1:0]             fwd_data,
  output logic                          ld_stall,
  output logic [$clog2(DEPTH+1)-1:0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int WA = DM_ADDRESS - 2;
  localparam int LW = DATA_W / 4;

  logic [PW-1:0]     head_reg, tail_reg;
  logic [CW-1:0]     count_reg;
  logic [DEPTH-1:0]  valid_reg, valid_next;

  // Payload storage carries no reset; valid_reg qualifies every entry.
  logic [WA-1:0]     waddr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [3:0]        be_mem    [DEPTH];

  logic              push, pop;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_lane_data;
  logic [WA-1:0]     ld_waddr;
  logic              match_found;
  logic              lane_ok;
  logic [PW-1:0]     idx;

  always_comb begin
    st_be        = 4'b1111;
    st_lane_data = st_data;
    case (st_funct3)
      3'b000: begin
        st_be        = 4'b0001 << st_addr[1:0];
        st_lane_data = {4{st_data[LW-1:0]}};
      end
      3'b001: begin
        st_be        = st_addr[1] ? 4'b1100 : 4'b0011;
        st_lane_data = {2{st_data[2*LW-1:0]}};
      end
      default: ;
    endcase
  end

  assign ld_waddr = ld_addr[DM_ADDRESS-1:2];

`ifdef STORE_BUF_FWD_EN
  logic [3:0]        ld_need;
  logic [3:0]        match_be;
  logic [DATA_W-1:0] match_data;
  logic              covered;

  always_comb begin
    ld_need = 4'b1111;
    case (ld_funct3)
      3'b000, 3'b100: ld_need = 4'b0001 << ld_addr[1:0];
      3'b001, 3'b101: ld_need = ld_addr[1] ? 4'b1100 : 4'b0011;
      default: ;
    endcase
  end
`else
  logic unused_ld;
  assign unused_ld = ^{ld_funct3, ld_addr[1:0]};
`endif

  // Walk oldest to youngest from the head so the last hit is the youngest store.
  always_comb begin
    match_found = 1'b0;
    idx         = '0;
    lane_ok     = 1'b0;
`ifdef STORE_BUF_FWD_EN
    match_be    = 4'b0000;
    match_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + PW'(k);
`ifdef STORE_BUF_FWD_EN
      lane_ok = (be_mem[idx] & ld_need) != 4'b0000;
`else
      lane_ok = 1'b1;
`endif
      if (valid_reg[idx] && (waddr_mem[idx] == ld_waddr) && lane_ok) begin
        match_found = 1'b1;
`ifdef STORE_BUF_FWD_EN
        match_be    = be_mem[idx];
        match_data  = data_mem[idx];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign covered  = (match_be & ld_need) == ld_need;
  assign fwd_hit  = ld_valid && match_found && covered;
  assign ld_stall = ld_valid && match_found && !covered;
  assign fwd_data = fwd_hit ? match_data : '0;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign ld_stall = ld_valid && match_found;
`endif

  // The memory port is free whenever no load is using it, or the load is stalled anyway.
  assign st_ready  = count_reg != CW'(DEPTH);
  assign push      = st_valid && st_ready;
  assign mem_we    = (count_reg != '0) && (!ld_valid || ld_stall);
  assign pop       = mem_we;
  assign mem_addr  = mem_we ? {waddr_mem[head_reg], 2'b00} : '0;
  assign mem_wdata = mem_we ? data_mem[head_reg] : '0;
  assign mem_wr    = mem_we ? be_mem[head_reg] : 4'b0000;
  assign count     = count_reg;

  always_comb begin
    valid_next = valid_reg;
    if (pop)  valid_next[head_reg] = 1'b0;
    if (push) valid_next[tail_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
      valid_reg <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      waddr_mem[tail_reg] <= st_addr[DM_ADDRESS-1:2];
      data_mem[tail_reg]  <= st_lane_data;
      be_mem[tail_reg]    <= st_be;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [8:0]  st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_funct3 = '0;
  logic        ld_valid = 1'b0;
  logic [8:0]  ld_addr = '0;
  logic [2:0]  ld_funct3 = '0;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        ld_stall;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH), .DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  w;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_we;
  logic        exp_hit;
  logic        exp_stall;
  logic [31:0] exp_fdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] st_mask(input logic [2:0] f, input logic [8:0] a);
    if (f == 3'd0) return 4'(1 << (int'(a) % 4));
    if (f == 3'd1) return ((int'(a) / 2) % 2 == 1) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] st_rep(input logic [2:0] f, input logic [31:0] d);
    if (f == 3'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (f == 3'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] ld_mask(input logic [2:0] f, input logic [8:0] a);
    if (int'(f) % 4 == 0) return 4'(1 << (int'(a) % 4));
    if (int'(f) % 4 == 1) return ((int'(a) / 2) % 2 == 1) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  // Expected outputs from the queue contents and the current inputs, then compare.
  task automatic model_check();
    logic [3:0] need;
    int         found;
    need      = ld_mask(ld_funct3, ld_addr);
    found     = -1;
    exp_hit   = 1'b0;
    exp_stall = 1'b0;
    exp_fdata = '0;
    if (ld_valid) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (found < 0 && q[i].w == ld_addr[8:2] && (!FWD || (q[i].be & need) != 4'h0))
          found = i;
      if (found >= 0) begin
        if (FWD && (q[found].be & need) == need) begin
          exp_hit   = 1'b1;
          exp_fdata = q[found].d;
        end else begin
          exp_stall = 1'b1;
        end
      end
    end
    exp_we = (q.size() > 0) && (!ld_valid || exp_stall);
    check("count", 32'(count), 32'(q.size()));
    check("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_wr", 32'(mem_wr), exp_we ? 32'(q[0].be) : 32'h0);
    if (exp_we) begin
      check("mem_addr", 32'(mem_addr), 32'({q[0].w, 2'b00}));
      check("mem_wdata", mem_wdata, q[0].d);
    end
    check("fwd_hit", 32'(fwd_hit), 32'(exp_hit));
    check("ld_stall", 32'(ld_stall), 32'(exp_stall));
    if (!ld_valid || exp_hit) check("fwd_data", fwd_data, exp_fdata);
  endtask

  task automatic cyc(input logic sv, input logic [8:0] sa, input logic [31:0] sd,
                     input logic [2:0] sf, input logic lv, input logic [8:0] la,
                     input logic [2:0] lf);
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
    ld_valid = lv; ld_addr = la; ld_funct3 = lf;
    #1;
    model_check();
  endtask

  task automatic adv();
    ent_t e;
    logic push;
    @(posedge clk);
    if (rst_n) begin
      push = st_valid && (q.size() < DEPTH);
      if (exp_we) begin
        $display("drain  addr=%03h data=%08h wr=%b", {q[0].w, 2'b00}, q[0].d, q[0].be);
        void'(q.pop_front());
      end
      if (push) begin
        e.w  = st_addr[8:2];
        e.d  = st_rep(st_funct3, st_data);
        e.be = st_mask(st_funct3, st_addr);
        $display("store  addr=%03h data=%08h f3=%0d", st_addr, st_data, st_funct3);
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b0, 9'h0, 3'd2);
      adv();
    end
  endtask

  initial begin
    logic [2:0] lfs[5];
    lfs[0] = 3'd0; lfs[1] = 3'd1; lfs[2] = 3'd2; lfs[3] = 3'd4; lfs[4] = 3'd5;

    #3;
    check("rst_count", 32'(count), 32'h0);
    check("rst_st_ready", 32'(st_ready), 32'h1);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW then drain next cycle
    cyc(1'b1, 9'h010, 32'hDEAD_BEEF, 3'd2, 1'b0, 9'h0, 3'd2); adv();
    cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b0, 9'h0, 3'd2);
    check("sw_mem_we", 32'(mem_we), 32'h1);
    check("sw_mem_addr", 32'(mem_addr), 32'h010);
    check("sw_mem_wr", 32'(mem_wr), 32'hF);
    check("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw_count1", 32'(count), 32'h1);
    adv();
    cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b0, 9'h0, 3'd2);
    check("sw_count0", 32'(count), 32'h0);
    adv();

    // SB byte lane 3
    cyc(1'b1, 9'h013, 32'h0000_00A5, 3'd0, 1'b0, 9'h0, 3'd2); adv();
    cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b0, 9'h0, 3'd2);
    check("sb_mem_wr", 32'(mem_wr), 32'h8);
    check("sb_mem_addr", 32'(mem_addr), 32'h010);
    check("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    adv();

    // Fill while a non-matching load holds the memory port
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 9'(9'h040 + 4 * i), 32'(32'h1000 + i), 3'd2, 1'b1, 9'h100, 3'd2);
      adv();
    end
    cyc(1'b1, 9'h050, 32'h5555, 3'd2, 1'b1, 9'h100, 3'd2);
    check("full_count", 32'(count), 32'h4);
    check("full_st_ready", 32'(st_ready), 32'h0);
    adv();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b0, 9'h0, 3'd2);
      check("fill_order_addr", 32'(mem_addr), 32'(9'h040 + 4 * i));
      check("fill_order_data", mem_wdata, 32'(32'h1000 + i));
      adv();
    end
    idle(1);

    // Forwarding of a full word to LBU
    cyc(1'b1, 9'h020, 32'h1122_3344, 3'd2, 1'b0, 9'h0, 3'd2); adv();
    cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b1, 9'h022, 3'd4);
    check("fwd_lbu_hit", 32'(fwd_hit), FWD ? 32'h1 : 32'h0);
    check("fwd_lbu_stall", 32'(ld_stall), FWD ? 32'h0 : 32'h1);
    check("fwd_lbu_data", fwd_data, FWD ? 32'h1122_3344 : 32'h0);
    adv();
    idle(2);

    // Partial coverage stalls until the entry drains
    cyc(1'b1, 9'h030, 32'h0000_0077, 3'd0, 1'b0, 9'h0, 3'd2); adv();
    cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b1, 9'h030, 3'd2);
    check("part_lw_stall", 32'(ld_stall), 32'h1);
    check("part_lw_hit", 32'(fwd_hit), 32'h0);
    adv();
    cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b1, 9'h030, 3'd2);
    check("part_lw_clear", 32'(ld_stall), 32'h0);
    adv();
    cyc(1'b1, 9'h030, 32'h0000_0077, 3'd0, 1'b0, 9'h0, 3'd2); adv();
    cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b1, 9'h031, 3'd4);
    check("nolap_lbu_stall", 32'(ld_stall), FWD ? 32'h0 : 32'h1);
    adv();
    idle(2);

    // Reset in the middle of draining three entries
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 9'(9'h080 + 4 * i), 32'(32'hAB00 + i), 3'd2, 1'b1, 9'h100, 3'd2);
      adv();
    end
    cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b0, 9'h0, 3'd2);
    check("pre_rst_count", 32'(count), 32'h3);
    check("pre_rst_we", 32'(mem_we), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'h0);
    check("rst_mid_count", 32'(count), 32'h0);
    check("rst_mid_wr", 32'(mem_wr), 32'h0);
    check("rst_mid_ready", 32'(st_ready), 32'h1);
    q.delete();
    adv();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 9'h0, 32'h0, 3'd2, 1'b0, 9'h0, 3'd2);
      check("post_rst_no_write", 32'(mem_we), 32'h0);
      adv();
    end

    // Random traffic over a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom % 2),
          9'(9'h060 + ($urandom % 4) * 4 + ($urandom % 4)),
          $urandom,
          3'($urandom % 3),
          1'($urandom % 3 == 0),
          9'(9'h060 + ($urandom % 4) * 4 + ($urandom % 4)),
          lfs[$urandom % 5]);
      adv();
    end
    idle(DEPTH + 1);
    check("final_empty", 32'(count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
